// File: rtl/repeated_sub_divider_pkg.sv
// Shared constants for the repeated-subtraction divider: operand width,
// FSM state encoding and the quotient reported on divide-by-zero.
package repeated_sub_divider_pkg;

   localparam int WIDTH = 16;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [15:0] DBZ_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/repeated_sub_divider_sub16_ge.sv
// Combinational subtract with borrow-out; ge doubles as the unsigned a >= b
// compare so the divider needs no separate comparator.
module sub16_ge #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             ge
);

   logic borrow;

   always_comb begin
      {borrow, diff} = {1'b0, a} - {1'b0, b};
      ge             = ~borrow;
   end

endmodule

// File: rtl/repeated_sub_divider.sv
// Unsigned divider: one subtract-and-count step per clock, with a
// start/busy/done handshake for the expression sequencer.
module repeated_sub_divider
   import repeated_sub_divider_pkg::*;
#(
   parameter int P_WIDTH = WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [P_WIDTH-1:0] dividend,
   input  logic [P_WIDTH-1:0] divisor,
   output logic [P_WIDTH-1:0] quotient,
   output logic [P_WIDTH-1:0] remainder,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero
);

   logic [1:0]         state_q, state_d;
   logic [P_WIDTH-1:0] rem_q, rem_d;
   logic [P_WIDTH-1:0] quo_q, quo_d;
   logic [P_WIDTH-1:0] dsr_q, dsr_d;
   logic               dbz_q, dbz_d;

   logic [P_WIDTH-1:0] diff;
   logic               ge;

   sub16_ge #(.WIDTH(P_WIDTH)) u_sub (
      .a    (rem_q),
      .b    (dsr_q),
      .diff (diff),
      .ge   (ge)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dsr_d   = dsr_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               rem_d = dividend;
               if (divisor == '0) begin
                  // No iteration possible; report all-ones quotient at once.
                  quo_d   = P_WIDTH'(DBZ_QUOTIENT);
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  dsr_d   = divisor;
                  quo_d   = '0;
                  dbz_d   = 1'b0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (ge) begin
               rem_d = diff;
               quo_d = quo_q + {{(P_WIDTH-1){1'b0}}, 1'b1};
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dsr_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dsr_q   <= dsr_d;
         dbz_q   <= dbz_d;
      end
   end

   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign div_by_zero = dbz_q & done;

endmodule
